// File: rtl/sd_tx_fifo_filler.sv
// -----------------------------------------------------------------------------
// sd_tx_fifo_filler
//
// Purpose: fetches a block of 32-bit words from a Wishbone slave, one access at
// a time, and pushes each word into the SD host TX FIFO. When the FIFO fills,
// fetching stalls until the occupancy drains to LOW_WATER or below.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   start, abort        transfer request (IDLE only) / cancel
//   base_adr, word_cnt  first byte address and number of words
//   busy, done, err     status: not idle / completion pulse / sticky bus error
//   m_wb_*              Wishbone read master (we=0, sel=4'hF)
//   fifo_d, fifo_wr     registered FIFO write data and one-cycle write strobe
//   fifo_full,
//   fifo_level          FIFO status from the TX FIFO
//
// States:
//   state  | meaning
//   IDLE   | waiting for start
//   REQ    | Wishbone read outstanding (cyc/stb high)
//   PUSH   | fetched word in fifo_d, write it to the FIFO
//   SETTLE | one cycle for fifo_level/fifo_full to reflect the write
//   WAIT   | FIFO full, hold off until level drops to LOW_WATER
// -----------------------------------------------------------------------------
module sd_tx_fifo_filler #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LOW_WATER  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] base_adr,
  input  logic [15:0] word_cnt,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] m_wb_adr_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  output logic        m_wb_we_o,
  output logic [3:0]  m_wb_sel_o,
  input  logic [31:0] m_wb_dat_i,
  input  logic        m_wb_ack_i,
  input  logic        m_wb_err_i,
  output logic [31:0] fifo_d,
  output logic        fifo_wr,
  input  logic        fifo_full,
  input  logic [5:0]  fifo_level
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_PUSH   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_WAIT   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] adr_q,   adr_d;
  logic [15:0] rem_q,   rem_d;
  logic [31:0] dat_q,   dat_d;
  logic        err_q,   err_d;
  logic        done_q,  done_d;

  logic        fifo_wr_c;
  logic        done_push_c;
  logic        full_w;
  logic        level_low_w;

  // Treat an occupancy at capacity as full even if the flag lags.
  assign full_w      = fifo_full || ({26'd0, fifo_level} >= 32'(FIFO_DEPTH));
  assign level_low_w = ({26'd0, fifo_level} <= 32'(LOW_WATER));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      adr_q   <= 32'd0;
      rem_q   <= 16'd0;
      dat_q   <= 32'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    rem_d       = rem_q;
    dat_d       = dat_q;
    err_d       = err_q;
    done_d      = 1'b0;
    fifo_wr_c   = 1'b0;
    done_push_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (word_cnt == 16'd0) begin
            done_d = 1'b1;
          end else begin
            adr_d   = base_adr;
            rem_d   = word_cnt;
            // Never open a bus cycle into a full FIFO; let WAIT hold it off.
            state_d = full_w ? ST_WAIT : ST_REQ;
          end
        end
      end

      ST_REQ: begin
        // abort wins over a same-cycle ack/err; err wins over ack.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (m_wb_err_i) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (m_wb_ack_i) begin
          dat_d   = m_wb_dat_i;
          adr_d   = adr_q + 32'd4;
          if (rem_q != 16'd0) begin
            rem_d = rem_q - 16'd1;
          end
          state_d = ST_PUSH;
        end
      end

      ST_PUSH: begin
        // If the FIFO is somehow full here, hold the word rather than drop it.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!full_w) begin
          fifo_wr_c = 1'b1;
          if (rem_q == 16'd0) begin
            done_push_c = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_SETTLE;
          end
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = full_w ? ST_WAIT : ST_REQ;
        end
      end

      ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (level_low_w && !full_w) begin
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus strobes decode straight from the state flop so reset clears them
  // without waiting for an edge.
  assign m_wb_cyc_o = (state_q == ST_REQ);
  assign m_wb_stb_o = (state_q == ST_REQ);
  assign m_wb_adr_o = adr_q;
  assign m_wb_we_o  = 1'b0;
  assign m_wb_sel_o = 4'hF;

  assign fifo_d  = dat_q;
  assign fifo_wr = fifo_wr_c;

  assign busy = (state_q != ST_IDLE);
  assign done = done_q || done_push_c;
  assign err  = err_q;

endmodule

// File: tb/tb_sd_tx_fifo_filler.sv
module tb_sd_tx_fifo_filler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] base_adr = 32'd0;
  logic [15:0] word_cnt = 16'd0;
  logic        busy, done, err;
  logic [31:0] m_wb_adr_o;
  logic        m_wb_cyc_o, m_wb_stb_o, m_wb_we_o;
  logic [3:0]  m_wb_sel_o;
  logic [31:0] m_wb_dat_i = 32'd0;
  logic        m_wb_ack_i = 1'b0;
  logic        m_wb_err_i = 1'b0;
  logic [31:0] fifo_d;
  logic        fifo_wr;
  logic        fifo_full;
  logic [5:0]  fifo_level;

  sd_tx_fifo_filler #(.FIFO_DEPTH(8), .LOW_WATER(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .base_adr   (base_adr),
    .word_cnt   (word_cnt),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .m_wb_adr_o (m_wb_adr_o),
    .m_wb_cyc_o (m_wb_cyc_o),
    .m_wb_stb_o (m_wb_stb_o),
    .m_wb_we_o  (m_wb_we_o),
    .m_wb_sel_o (m_wb_sel_o),
    .m_wb_dat_i (m_wb_dat_i),
    .m_wb_ack_i (m_wb_ack_i),
    .m_wb_err_i (m_wb_err_i),
    .fifo_d     (fifo_d),
    .fifo_wr    (fifo_wr),
    .fifo_full  (fifo_full),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // FIFO model state
  int level    = 0;
  int drain_to = 99;
  bit wr_pend  = 1'b0;
  assign fifo_level = level[5:0];
  assign fifo_full  = (level >= 8);

  // Slave model state
  bit          seen    = 1'b0;
  logic [31:0] err_adr = 32'hFFFF_FFFF;

  // Monitor logs
  logic [31:0] wr_log[$];
  logic [31:0] adr_log[$];
  int wr_cnt = 0, done_cnt = 0, cyc_cnt = 0, wr_full_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wishbone slave: ack (or err at err_adr) one cycle after stb is seen.
  always @(posedge clk) begin
    #1;
    if (m_wb_ack_i || m_wb_err_i) begin
      m_wb_ack_i = 1'b0;
      m_wb_err_i = 1'b0;
      seen = 1'b0;
    end else if (m_wb_cyc_o && m_wb_stb_o) begin
      if (seen) begin
        if (m_wb_adr_o == err_adr) m_wb_err_i = 1'b1;
        else begin
          m_wb_ack_i = 1'b1;
          m_wb_dat_i = m_wb_adr_o ^ 32'h5A5A_0000;
        end
      end else begin
        seen = 1'b1;
      end
    end else begin
      seen = 1'b0;
    end
  end

  // FIFO occupancy: a write sampled in a cycle lands just after the next edge.
  always @(posedge clk) begin
    #1;
    if (wr_pend) level = level + 1;
    if (level > drain_to) level = level - 1;
  end

  always @(negedge clk) begin
    wr_pend = fifo_wr;
    if (fifo_wr) begin
      wr_log.push_back(fifo_d);
      wr_cnt++;
      if (fifo_full) wr_full_cnt++;
    end
    if (done) done_cnt++;
    if (m_wb_cyc_o) cyc_cnt++;
    if (m_wb_cyc_o && (m_wb_ack_i || m_wb_err_i)) adr_log.push_back(m_wb_adr_o);
  end

  task automatic do_start(input logic [31:0] a, input logic [15:0] n);
    @(negedge clk);
    base_adr = a;
    word_cnt = n;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    bit got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk(tag, {31'd0, got}, 32'd1);
  endtask

  task automatic flush_fifo();
    drain_to = 0;
    repeat (12) @(negedge clk);
    drain_to = 99;
  endtask

  int wb, ab, db, cb;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cyc", {31'd0, m_wb_cyc_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_wr", {31'd0, fifo_wr}, 32'd0);
    chk("reset_stb", {31'd0, m_wb_stb_o}, 32'd0);
    chk("reset_adr", m_wb_adr_o, 32'd0);
    chk("reset_fifo_d", fifo_d, 32'd0);
    chk("we_const", {31'd0, m_wb_we_o}, 32'd0);
    chk("sel_const", {28'd0, m_wb_sel_o}, 32'hF);

    // Three-word transfer, with a start while busy that must be ignored
    wb = wr_cnt; ab = adr_log.size(); db = done_cnt;
    do_start(32'h1000, 16'd3);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    do_start(32'h8000, 16'd5);
    wait_done("t3_done_timeout", 200);
    repeat (3) @(negedge clk);
    chk("t3_writes", wr_cnt - wb, 3);
    chk("t3_adr0", adr_log[ab],   32'h1000);
    chk("t3_adr1", adr_log[ab+1], 32'h1004);
    chk("t3_adr2", adr_log[ab+2], 32'h1008);
    chk("t3_dat0", wr_log[wb],    32'h5A5A_1000);
    chk("t3_dat1", wr_log[wb+1],  32'h5A5A_1004);
    chk("t3_dat2", wr_log[wb+2],  32'h5A5A_1008);
    chk("t3_done_pulses", done_cnt - db, 1);
    chk("t3_busy_after", {31'd0, busy}, 32'd0);
    chk("t3_reads", adr_log.size() - ab, 3);

    // Zero-length request
    flush_fifo();
    wb = wr_cnt; cb = cyc_cnt;
    do_start(32'h2000, 16'd0);
    chk("z_done_next", {31'd0, done}, 32'd1);
    chk("z_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("z_done_single", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    chk("z_no_cyc", cyc_cnt - cb, 0);
    chk("z_no_wr", wr_cnt - wb, 0);

    // FIFO fill stall with hysteresis
    flush_fifo();
    wb = wr_cnt; db = done_cnt;
    do_start(32'h0100, 16'd12);
    repeat (80) @(negedge clk);
    chk("fill_writes", wr_cnt - wb, 8);
    chk("fill_level", level, 8);
    chk("fill_busy", {31'd0, busy}, 32'd1);
    chk("fill_no_cyc", {31'd0, m_wb_cyc_o}, 32'd0);
    cb = cyc_cnt;
    drain_to = 2;
    begin
      bit got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        if (m_wb_cyc_o) got = 1'b1;
      end
      chk("resume_timeout", {31'd0, got}, 32'd1);
    end
    chk("resume_level", level, 2);
    wait_done("fill_done_timeout", 200);
    repeat (3) @(negedge clk);
    chk("fill_total", wr_cnt - wb, 12);
    chk("fill_last_dat", wr_log[wb+11], 32'h0100_012C ^ 32'h5A5B_0000 ^ 32'h0101_0000);
    chk("fill_done_pulses", done_cnt - db, 1);
    drain_to = 99;

    // Bus error on the second of four reads
    flush_fifo();
    wb = wr_cnt; db = done_cnt;
    err_adr = 32'h2004;
    do_start(32'h2000, 16'd4);
    wait_done("e_done_timeout", 200);
    repeat (3) @(negedge clk);
    chk("e_writes", wr_cnt - wb, 1);
    chk("e_err", {31'd0, err}, 32'd1);
    chk("e_done_pulses", done_cnt - db, 1);
    chk("e_idle", {31'd0, busy}, 32'd0);
    err_adr = 32'hFFFF_FFFF;
    do_start(32'h2100, 16'd1);
    chk("e_err_cleared", {31'd0, err}, 32'd0);
    wait_done("e2_done_timeout", 200);

    // Abort coincident with the second ack
    flush_fifo();
    wb = wr_cnt; db = done_cnt;
    do_start(32'h3000, 16'd4);
    begin
      bit got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        @(negedge clk);
        if (m_wb_ack_i && m_wb_adr_o == 32'h3004) got = 1'b1;
      end
      chk("a_ack_timeout", {31'd0, got}, 32'd1);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("a_idle_next", {31'd0, busy}, 32'd0);
    chk("a_cyc_low", {31'd0, m_wb_cyc_o}, 32'd0);
    repeat (5) @(negedge clk);
    chk("a_writes", wr_cnt - wb, 1);
    chk("a_no_done", done_cnt - db, 0);
    chk("a_err_kept", {31'd0, err}, 32'd0);

    // Asynchronous reset while stb is high
    flush_fifo();
    db = done_cnt;
    do_start(32'h4000, 16'd2);
    chk("r_stb_high", {31'd0, m_wb_stb_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("r_cyc", {31'd0, m_wb_cyc_o}, 32'd0);
    chk("r_stb", {31'd0, m_wb_stb_o}, 32'd0);
    chk("r_busy", {31'd0, busy}, 32'd0);
    chk("r_done", {31'd0, done}, 32'd0);
    chk("r_err", {31'd0, err}, 32'd0);
    chk("r_wr", {31'd0, fifo_wr}, 32'd0);
    chk("r_adr", m_wb_adr_o, 32'd0);
    chk("r_fifo_d", fifo_d, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("r_no_done", done_cnt - db, 0);
    chk("r_still_idle", {31'd0, busy}, 32'd0);

    chk("never_wr_full", wr_full_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_tx_fifo_filler.md
SD_TX_FIFO_FILLER -- requirements
Module: sd_tx_fifo_filler

Interface
REQ-001 Parameter: FIFO_DEPTH, default 8, TX FIFO capacity in 32-bit words.
REQ-002 Parameter: LOW_WATER, default 2, fifo_level at or below which fetching resumes after a full stall.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 start  in  1  one-cycle transfer request; sampled only in IDLE.
REQ-006 abort  in  1  cancel the current transfer.
REQ-007 base_adr  in  32  byte address of the first word.
REQ-008 word_cnt  in  16  number of 32-bit words to transfer.
REQ-009 busy  out  1  high in any state other than IDLE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  bus error flag; sticky until the next accepted start.
REQ-012 m_wb_adr_o  out  32; m_wb_cyc_o, m_wb_stb_o  out  1; m_wb_we_o  out  1, constant 0; m_wb_sel_o  out  4, constant 4'hF.
REQ-013 m_wb_dat_i  in  32; m_wb_ack_i, m_wb_err_i  in  1.
REQ-014 fifo_d  out  32  registered write data to the TX FIFO.
REQ-015 fifo_wr  out  1  one-cycle FIFO write strobe.
REQ-016 fifo_full  in  1; fifo_level  in  6  current FIFO occupancy in words.

Function
REQ-017 The block SHALL implement these states: IDLE, REQ, PUSH, SETTLE, WAIT.
REQ-018 IDLE: on start with word_cnt!=0, the block SHALL load the address register with base_adr and the remaining-word counter with word_cnt, clear err, and go to REQ.
REQ-019 IDLE: on start with word_cnt==0, the block SHALL pulse done in the next cycle, issue no bus cycle, and stay in IDLE.
REQ-020 REQ: the block SHALL hold m_wb_cyc_o=m_wb_stb_o=1 with m_wb_adr_o equal to the address register until ack or err; only one access is outstanding at a time.
REQ-021 REQ with ack: the block SHALL register m_wb_dat_i into fifo_d, drop cyc/stb in the next cycle, add 4 to the address modulo 2^32, decrement the remaining count, and go to PUSH.
REQ-022 PUSH: the block SHALL assert fifo_wr for exactly one cycle.
REQ-023 PUSH: if the remaining count is 0, the block SHALL pulse done in the same cycle and go to IDLE; otherwise it SHALL go to SETTLE.
REQ-024 SETTLE: a single cycle that allows fifo_level to update; if fifo_full=1 the next state SHALL be WAIT, else REQ.
REQ-025 WAIT: the block SHALL assert no bus cycle and go to REQ once fifo_level <= LOW_WATER (hysteresis).
REQ-026 The block SHALL never assert fifo_wr while fifo_full=1, and SHALL never start a REQ while fifo_full=1.
REQ-027 REQ with m_wb_err_i: the block SHALL drop cyc/stb, set err, write nothing to the FIFO, pulse done, and go to IDLE.
REQ-028 ack and err asserted together: the block SHALL treat the cycle as err.
REQ-029 abort in any non-IDLE state: the block SHALL go to IDLE in the next cycle with cyc/stb low, issue no fifo_wr, and leave done and err unchanged.
REQ-030 abort takes priority over ack or err arriving in the same cycle; the acked data SHALL be discarded.
REQ-031 start while busy SHALL be ignored.
REQ-032 The remaining counter SHALL be 16 bits and SHALL not underflow.

Reset
REQ-033 On rst the block SHALL go to IDLE with busy, done, err, fifo_wr, m_wb_cyc_o and m_wb_stb_o all 0, and fifo_d, m_wb_adr_o and the remaining counter all 0.
REQ-034 rst mid-transfer SHALL drop cyc/stb immediately (asynchronously), discard any pending data and issue no done.

Verification
REQ-035 start, base_adr=32'h1000, word_cnt=3, ack one cycle after stb, FIFO empty -> reads at 0x1000, 0x1004, 0x1008; 3 fifo_wr pulses carrying the data in order; a single done pulse; busy low afterwards.
REQ-036 word_cnt=0 -> done one cycle after start; no cyc and no fifo_wr.
REQ-037 FIFO_DEPTH=8, LOW_WATER=2, word_cnt=12, no FIFO drain -> exactly 8 writes, then WAIT with no bus activity; drain until fifo_level=2 -> fetching resumes; 12 writes in total.
REQ-038 m_wb_err_i on the 2nd read of 4 -> 1 fifo_wr; err=1; done pulse; IDLE; the next start clears err.
REQ-039 abort coincident with ack on the 2nd read -> no 2nd fifo_wr; IDLE next cycle; no done pulse.
REQ-040 rst asserted while stb is high -> cyc/stb low without waiting for a clock edge; every output at its REQ-033 value.
